sr_stack_fifo: RTL and testbench

First-word-fall-through FIFO that backs the CPU's custom PUSH/POP instructions. It sits beside the single-cycle core's register-file write-back path. PUSH enqueues a value in the cycle it executes. POP must return the head entry combinationally in the same cycle, so that entry is written to the register file at the next clock edge. The block adds occupancy and status reporting, sticky error flags and a debug peek port for the board-level debug path.

---
 rtl/sr_stack_fifo.sv | 134 +++++++++++++
 tb/tb_sr_stack_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_stack_fifo.sv
// sr_stack_fifo: first-word-fall-through FIFO backing the PUSH/POP instructions.
// The head entry is presented combinationally on dout so a POP can write it to
// the register file at the next edge. Status, sticky error flags and a
// read-only peek port for board-level debug are provided alongside.
module sr_stack_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AFULL_LVL  = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic                       push,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       empty,
  output logic                       full,
  output logic                       almostFull,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       errClr,
  input  logic [$clog2(DEPTH)-1:0]   dbgIdx,
  output logic [DATA_WIDTH-1:0]      dbgData
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Storage and state
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wp;
  logic [PTR_W-1:0]      r_rp;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  // Derived control
  logic                  w_empty;
  logic                  w_full;
  logic                  w_do_push;
  logic                  w_do_pop;
  logic                  w_push_drop;
  logic                  w_pop_empty;
  logic [PTR_W-1:0]      w_peek_addr;
  logic                  w_peek_valid;
  logic [CNT_W-1:0]      w_count_nxt;

  // Status flags come only from the count register, never from push/pop
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == CNT_W'(DEPTH));
  end

  // Effective operations this cycle; a pop frees a slot for a push when full
  always_comb begin
    w_do_push   = push & (~w_full | pop);
    w_do_pop    = pop & ~w_empty;
    w_push_drop = push & w_full & ~pop;
    w_pop_empty = pop & w_empty;
  end

  // Next occupancy: simultaneous push and pop leaves count unchanged
  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_do_pop && !w_do_push) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers; pointers wrap by natural overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wp <= r_wp + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rp <= r_rp + PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Storage write; contents are not reset, outputs are gated by count instead
  always_ff @(posedge clk) begin
    if (rst_n && w_do_push) begin
      r_mem[r_wp] <= din;
    end
  end

  // Sticky error flags; a new error in the errClr cycle keeps the flag set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (errClr) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end
      if (w_push_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_pop_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Debug peek: offset from head, wrapping, hidden beyond the valid entries
  always_comb begin
    w_peek_addr  = r_rp + dbgIdx;
    w_peek_valid = ({1'b0, dbgIdx} < r_count);
  end

  // Output drive; unwritten storage is never exposed
  always_comb begin
    dout       = w_empty ? '0 : r_mem[r_rp];
    dbgData    = w_peek_valid ? r_mem[w_peek_addr] : '0;
    empty      = w_empty;
    full       = w_full;
    almostFull = (r_count >= CNT_W'(AFULL_LVL));
    count      = r_count;
    overflow   = r_overflow;
    underflow  = r_underflow;
  end

endmodule

// File: tb/tb_sr_stack_fifo.sv
// tb_sr_stack_fifo: directed scenario bench for sr_stack_fifo (DEPTH=8, 16-bit).
module tb_sr_stack_fifo;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] din;
  logic          push;
  logic          pop;
  logic [DW-1:0] dout;
  logic          empty;
  logic          full;
  logic          almostFull;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;
  logic          errClr;
  logic [2:0]    dbgIdx;
  logic [DW-1:0] dbgData;

  int errors;
  int checks;

  sr_stack_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LVL(DEPTH - 1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .push(push), .pop(pop),
    .dout(dout), .empty(empty), .full(full), .almostFull(almostFull),
    .count(count), .overflow(overflow), .underflow(underflow),
    .errClr(errClr), .dbgIdx(dbgIdx), .dbgData(dbgData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; errClr = 1'b0; din = '0; dbgIdx = '0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (almostFull !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b exp=0", almostFull); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout got=%h exp=0000", dout); end
    checks++; if (dbgData !== 16'h0000) begin errors++; $display("FAIL reset_dbg got=%h exp=0000", dbgData); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", overflow, underflow); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] vals [3];
    vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033;
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; din = vals[i];
      #1;
      checks++; if (count !== 4'(i)) begin errors++; $display("FAIL basic_no_bypass_count got=%0d exp=%0d", count, i); end
      tick();
    end
    push = 1'b0;
    #1;
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL basic_count got=%0d exp=3", count); end
    checks++; if (dout !== 16'h0011) begin errors++; $display("FAIL basic_head got=%h exp=0011", dout); end
    for (int i = 0; i < 3; i++) begin
      pop = 1'b1;
      #1;
      checks++; if (dout !== vals[i]) begin errors++; $display("FAIL basic_pop%0d got=%h exp=%h", i, dout, vals[i]); end
      tick();
    end
    pop = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty got=%b exp=1", empty); end
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL basic_dout_empty got=%h exp=0000", dout); end
  endtask

  task automatic fill_0100();
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; din = 16'h0100 + 16'(i);
      tick();
      push = 1'b0;
      #1;
      if (i == 5) begin
        checks++; if (almostFull !== 1'b0) begin errors++; $display("FAIL afull_at6 got=%b exp=0", almostFull); end
      end
      if (i == 6) begin
        checks++; if (almostFull !== 1'b1) begin errors++; $display("FAIL afull_at7 got=%b exp=1", almostFull); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_at7 got=%b exp=0", full); end
      end
    end
  endtask

  task automatic test_overflow();
    fill_0100();
    push = 1'b1; din = 16'hDEAD;
    tick();
    push = 1'b0;
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", full); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count got=%0d exp=8", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    dbgIdx = 3'd7;
    #1;
    checks++; if (dbgData !== 16'h0107) begin errors++; $display("FAIL ovf_peek7 got=%h exp=0107", dbgData); end
    dbgIdx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1;
      #1;
      checks++; if (dout !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, dout, 16'h0100 + 16'(i)); end
      tick();
    end
    pop = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty_after_drain got=%b exp=1", empty); end
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    #1;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] exp_v;
    fill_0100();
    push = 1'b1; pop = 1'b1; din = 16'hBEEF;
    #1;
    checks++; if (dout !== 16'h0100) begin errors++; $display("FAIL fpp_dout got=%h exp=0100", dout); end
    tick();
    push = 1'b0; pop = 1'b0;
    #1;
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL fpp_count got=%0d exp=8", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_no_ovf got=%b exp=0", overflow); end
    for (int i = 0; i < 8; i++) begin
      exp_v = (i == 7) ? 16'hBEEF : 16'h0101 + 16'(i);
      pop = 1'b1;
      #1;
      checks++; if (dout !== exp_v) begin errors++; $display("FAIL fpp_drain%0d got=%h exp=%h", i, dout, exp_v); end
      tick();
    end
    pop = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fpp_empty got=%b exp=1", empty); end
  endtask

  task automatic test_underflow();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    #1;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_set got=%b exp=1", underflow); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL udf_count got=%0d exp=0", count); end
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    #1;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL udf_clear got=%b exp=0", underflow); end
    pop = 1'b1; errClr = 1'b1;
    tick();
    pop = 1'b0; errClr = 1'b0;
    #1;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_set_wins got=%b exp=1", underflow); end
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    // push and pop together while empty: no bypass, push accepted, underflow set
    push = 1'b1; pop = 1'b1; din = 16'h4242;
    #1;
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL epp_dout got=%h exp=0000", dout); end
    tick();
    push = 1'b0; pop = 1'b0;
    #1;
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL epp_count got=%0d exp=1", count); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL epp_udf got=%b exp=1", underflow); end
    checks++; if (dout !== 16'h4242) begin errors++; $display("FAIL epp_head got=%h exp=4242", dout); end
    pop = 1'b1; errClr = 1'b1;
    tick();
    pop = 1'b0; errClr = 1'b0;
    #1;
    checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL epp_cleanup got=%b%b exp=10", empty, underflow); end
  endtask

  task automatic test_back_to_back();
    push = 1'b1; din = 16'd1;
    tick();
    for (int v = 2; v <= 21; v++) begin
      push = (v <= 20); pop = 1'b1; din = 16'(v);
      dbgIdx = 3'd0;
      #1;
      checks++; if (dout !== 16'(v - 1)) begin errors++; $display("FAIL wrap_dout%0d got=%h exp=%h", v - 1, dout, 16'(v - 1)); end
      checks++; if (dbgData !== dout) begin errors++; $display("FAIL wrap_peek0_%0d got=%h exp=%h", v - 1, dbgData, 16'(v - 1)); end
      dbgIdx = 3'd1;
      #1;
      checks++; if (dbgData !== 16'h0000) begin errors++; $display("FAIL wrap_peek1_%0d got=%h exp=0000", v - 1, dbgData); end
      tick();
    end
    push = 1'b0; pop = 1'b0; dbgIdx = 3'd0;
    #1;
    checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL wrap_end got=%b%b exp=10", empty, underflow); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; din = 16'h0050 + 16'(i);
      tick();
    end
    push = 1'b0;
    #1;
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL mrst_pre_count got=%0d exp=5", count); end
    rst_n = 1'b0; push = 1'b1; din = 16'h7777;
    tick();
    rst_n = 1'b1; push = 1'b0;
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL mrst_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mrst_empty got=%b exp=1", empty); end
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL mrst_dout got=%h exp=0000", dout); end
    checks++; if (dbgData !== 16'h0000) begin errors++; $display("FAIL mrst_dbg got=%h exp=0000", dbgData); end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    #1;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL mrst_udf got=%b exp=1", underflow); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
